serial_adder: RTL
=================

# serial_adder

Bit-serial adder that computes a WIDTH-bit sum plus carry-out by passing one operand bit pair per clock cycle through a single `full_adder` instance. The carry is held in a flip-flop between cycles. The block sits directly upstream of `full_adder` and drives its `a`, `b` and `cin` inputs from operand shift registers. It trades latency for area in arithmetic datapaths, accepts operands through a start/busy/done handshake, and holds each registered result until the next operation completes.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and sum width in bits. Must be ≥ 1.

**Ports** (name, direction, width, meaning)
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `start`, input, 1: request to begin an addition; sampled on `clk` rising edges.
- `a`, input, WIDTH: operand A; sampled only when `start` is accepted.
- `b`, input, WIDTH: operand B; sampled only when `start` is accepted.
- `cin`, input, 1: carry-in; sampled only when `start` is accepted.
- `busy`, output, 1: high while an addition is in progress.
- `done`, output, 1: one-cycle pulse marking the cycle in which `sum`/`cout` are first valid.
- `sum`, output, WIDTH: registered result.
- `cout`, output, 1: registered carry-out.

## Operation

- **Datapath.** Exactly one `full_adder` instance.
  - Its `a`/`b` inputs are the LSBs of the internal operand shift registers `sa`/`sb`.
  - Its `cin` input is the carry flip-flop `cy`.
- **State machine.** States are IDLE, RUN and DONE.
- **IDLE.**
  - `busy` = 0.
  - `start` = 1 loads `sa`←`a`, `sb`←`b`, `cy`←`cin`, bit counter `cnt`←0, and moves to RUN.
- **RUN.** One bit per cycle, LSB first. On each edge:
  - `sa`/`sb` shift right by 1.
  - `cy` ← full_adder `carry`.
  - The full_adder `sum` bit shifts into the MSB of the partial-sum register `ps`.
  - `cnt` increments.
  - When `cnt` == WIDTH-1 on the edge, that edge processes the final bit and also:
    - loads `sum` ← the completed partial sum (including that final bit);
    - loads `cout` ← the final carry;
    - moves to DONE.
- **DONE.**
  - `done` = 1 and `busy` = 0 for exactly one cycle.
  - `start` = 1 in DONE is accepted exactly as in IDLE, going straight to RUN. Otherwise the next state is IDLE.
- **Start while busy.** `start` asserted in RUN is ignored. Operands are not resampled and no error is flagged.
- **Output hold.** `sum`/`cout` change only on the completing edge. They hold the last result through IDLE and through any following RUN until the next completion.
- **Arithmetic.** {`cout`,`sum`} = `a` + `b` + `cin`, computed modulo 2^(WIDTH+1). There is no overflow flag.
- **Counter.** `cnt` width is $clog2(WIDTH), minimum 1 bit.
- **WIDTH = 1.** RUN lasts one cycle.
- **Reset.** Asserting `rst_n` low clears the following immediately, independent of `clk`:
  - state → IDLE;
  - `busy`, `done`, `sum`, `cout`, `cy`, `cnt`, `sa`, `sb`, `ps` → 0.
- **Reset mid-operation.** An addition in flight is aborted. No `done` is produced for it. The first accepted `start` after `rst_n` returns high starts a clean operation.

## Timing

- **Acceptance.** Call the edge at which `start` is accepted E0.
- **busy.** Goes high after E0 and stays high through edges E1..E(WIDTH-1). It is low after edge E(WIDTH).
- **Result.** Bits are processed at edges E1..E(WIDTH). `sum`/`cout` are updated and `done` rises after edge E(WIDTH).
  - Latency from start edge to valid result: WIDTH cycles.
- **done.** Falls after edge E(WIDTH+1).
- **Throughput.** If `start` is held high in the DONE cycle, the next operation's E0 is E(WIDTH+1). Sustained throughput is one addition per WIDTH+1 cycles.
- **Combinational paths.** None from inputs to outputs; all outputs are registered.
- **Reset values.** All outputs are 0 while `rst_n` = 0 and after release.

## Test plan

- **Basic add.** WIDTH=8; `a`=0x5A, `b`=0x3C, `cin`=0, 1-cycle `start` → `busy` high for 8 cycles; `done` pulses once 8 cycles after the start edge; `sum`=0x96, `cout`=0.
- **Full carry ripple.** `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1. Then `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Start while busy.** Start 0x10+0x20; re-pulse `start` with `a`=0xAA, `b`=0x55 at cycle 3 of RUN → single `done` with `sum`=0x30, `cout`=0; `busy` falls on schedule.
- **Back-to-back.** Hold `start` high with operands 0x01+0x02, then switch the operands to 0x80+0x80 in the DONE cycle → two `done` pulses 9 cycles apart; results 0x03/0 then 0x00/1; `sum` holds 0x03 until the second completion.
- **Reset mid-operation.** Drive `rst_n` low for 1 cycle 4 cycles into RUN → `busy`/`done`/`sum`/`cout` = 0 immediately and no `done` afterwards. A new start with 0x7F+0x01 yields 0x80/0.
- **Randomized check.** 1000 random operand sets at WIDTH=8 and WIDTH=1 → {`cout`,`sum`} equals `a`+`b`+`cin` every time, with `done` exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. Each addition runs one operand bit pair per clock, LSB
// first, through a single full_adder. The carry lives in a flip-flop between
// bits, and the sum bits are collected in a partial-sum shift register.
//
// Handshake (valid/ready): `start` is a request. It is accepted on any rising
// edge where the block is not busy, that is in the IDLE or DONE state. When it
// is accepted, a/b/cin are captured on that same edge. While `busy` is high,
// `start` is ignored. `done` pulses for one cycle, and that is the first cycle
// in which the new sum/cout are valid. There is no back-pressure on the result.
// sum/cout hold their value until the next addition completes.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request to begin an addition
//   a      in   WIDTH  operand A (captured at acceptance)
//   b      in   WIDTH  operand B (captured at acceptance)
//   cin    in   1      carry-in   (captured at acceptance)
//   busy   out  1      addition in progress
//   done   out  1      one-cycle pulse: sum/cout just updated
//   sum    out  WIDTH  registered sum
//   cout   out  1      registered carry-out
//
// The FSM state is available as the internal signal state_q for debug and
// checker binding.
// -----------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .cin   (cy_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new request exactly like IDLE, so a held start
        // gives one addition every WIDTH+1 cycles.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cy_d    = cin;
          ps_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cy_d  = fa_carry;
        // The new sum bit enters at the MSB. After WIDTH shifts the first
        // (LSB) bit has reached bit 0.
        ps_d  = ps_q >> 1;
        ps_d[WIDTH-1] = fa_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = ps_d;
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy/done are registered copies of the next-state decode. This keeps
    // every output a flop with no input-to-output path.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
